mse_serial_master: RTL

- Initiator end of the MSE serial link: the host-side master that drives SCLK/SLE/SDO and samples SDI/SRDY of the FPGA serial slave (qsys serial host port).
- Converts single read/write commands on a valid/ready interface into framed serial transactions.
- Used in the MCU-replacement/test FPGA and in bench loopback against the slave.

---
 rtl/mse_serial_pkg.sv | 25 ++
 rtl/mse_sclk_gen.sv | 53 +++++
 rtl/mse_serial_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mse_serial_pkg.sv
// Shared definitions for the MSE serial link: the master FSM states, the
// command byte layout and the default timing values the slave model also uses.
package mse_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    WAIT  = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5,
    GAP   = 3'd6
  } state_e;

  localparam int CMD_W       = 8;
  localparam int WR_BIT      = 7;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_TIMEOUT = 4096;

  // Command byte sent first on the wire: write flag in the top bit, then the address.
  function automatic logic [CMD_W-1:0] make_cmd(input logic wr, input logic [WR_BIT-1:0] addr);
    return {wr, addr};
  endfunction

endpackage

// File: rtl/mse_sclk_gen.sv
// SCLK half-period generator: toggles sclk every CLK_DIV enabled clocks and
// flags the clock edges on which sclk rises or falls.
module mse_sclk_gen
  import mse_serial_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_evt_o,
  output logic fall_evt_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap_s;

  assign wrap_s     = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_evt_o = wrap_s && !sclk_q;
  assign fall_evt_o = wrap_s && sclk_q;
  assign sclk_o     = sclk_q;

  // Counter and sclk next state; disabling parks the clock low and restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // Counter and sclk registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/mse_serial_master.sv
// Host-side master of the MSE serial link: turns one read/write command into a
// framed SLE/SCLK/SDO transaction and reports the result on a response pulse.
module mse_serial_master
  import mse_serial_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              ser_sclk,
  output logic              ser_sle,
  output logic              ser_sdo,
  input  logic              ser_sdi,
  input  logic              ser_srdy
);

  localparam int TX_W = CMD_W - 1 + DATA_W;
  localparam int BW   = $clog2(DATA_W + 1);
  localparam int TW   = $clog2((TIMEOUT > CLK_DIV) ? TIMEOUT : CLK_DIV);

  state_e            state_q, state_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     to_q, to_d;
  logic              wr_q, wr_d;
  logic              sle_q, sle_d;
  logic              sdo_q, sdo_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              cmd_ready_q, busy_q;
  logic              srdy_meta_q, srdy_sync_q;

  logic              sclk_en_s, rise_evt_s, fall_evt_s;
  logic [CMD_W-1:0]  cmd_s;
  logic [BW-1:0]     last_bit_s;

  assign cmd_s      = make_cmd(cmd_write, cmd_addr[WR_BIT-1:0]);
  assign sclk_en_s  = (state_q == CMD) || (state_q == WDATA) || (state_q == RDATA);
  assign last_bit_s = (state_q == CMD) ? BW'(CMD_W - 1) : BW'(DATA_W - 1);

  mse_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i      (csi_MCLK_clk),
    .rst_i      (rsi_MRST_reset),
    .en_i       (sclk_en_s),
    .sclk_o     (ser_sclk),
    .rise_evt_o (rise_evt_s),
    .fall_evt_o (fall_evt_s)
  );

  // Frame sequencing; sdo only changes together with a falling sclk edge.
  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    bit_d         = bit_q;
    to_d          = to_q;
    wr_d          = wr_q;
    sle_d         = sle_q;
    sdo_d         = sdo_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = CMD;
          wr_d    = cmd_write;
          tx_d    = {cmd_s[CMD_W-2:0], cmd_wdata};
          sle_d   = 1'b1;
          sdo_d   = cmd_s[WR_BIT];
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD, WDATA: begin
        if (fall_evt_s) begin
          tx_d  = {tx_q[TX_W-2:0], 1'b0};
          sdo_d = tx_q[TX_W-1];
          if (bit_q == last_bit_s) begin
            bit_d = '0;
            if ((state_q == CMD) && wr_q) begin
              state_d = WDATA;
            end else begin
              state_d = WAIT;
              sdo_d   = 1'b0;
              to_d    = '0;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          bit_d = bit_q;
        end
      end
      WAIT: begin
        if (srdy_sync_q) begin
          if (wr_q) begin
            state_d       = DONE;
            sle_d         = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = RDATA;
            rx_d    = '0;
            bit_d   = '0;
          end
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d       = DONE;
          sle_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RDATA: begin
        if (rise_evt_s) begin
          rx_d = {rx_q[DATA_W-2:0], ser_sdi};
        end else if (fall_evt_s) begin
          if (bit_q == last_bit_s) begin
            state_d       = DONE;
            sle_d         = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = rx_q;
            rsp_timeout_d = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          rx_d = rx_q;
        end
      end
      DONE: begin
        state_d = GAP;
        to_d    = '0;
      end
      GAP: begin
        if (to_q == TW'(CLK_DIV - 1)) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sle_d   = 1'b0;
        sdo_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; cmd_ready/busy follow the upcoming state.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q       <= IDLE;
      tx_q          <= '0;
      rx_q          <= '0;
      bit_q         <= '0;
      to_q          <= '0;
      wr_q          <= 1'b0;
      sle_q         <= 1'b0;
      sdo_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      bit_q         <= bit_d;
      to_q          <= to_d;
      wr_q          <= wr_d;
      sle_q         <= sle_d;
      sdo_q         <= sdo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_ready_q   <= (state_d == IDLE);
      busy_q        <= (state_d != IDLE);
    end
  end

  // Two-stage synchronizer for the asynchronous slave ready.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      srdy_meta_q <= 1'b0;
      srdy_sync_q <= 1'b0;
    end else begin
      srdy_meta_q <= ser_srdy;
      srdy_sync_q <= srdy_meta_q;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign ser_sle     = sle_q;
  assign ser_sdo     = sdo_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
